// File: rtl/sram_1rw_req_ctrl.sv
// sram_1rw_req_ctrl: valid/ready request front end for a single-port 1rw SRAM macro.
// After reset it clears the array. It then issues requests straight to the macro
// in the same cycle they are accepted. Read data is caught from dout0 one edge
// later and parked in a small first-word-fall-through response FIFO.
module sram_1rw_req_ctrl #(
    parameter int                    DATA_WIDTH = 2,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    RSP_DEPTH  = 4,
    parameter bit                    INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W     = $clog2(RSP_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] init_ptr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  rd_inflight;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      outstanding;
    logic                  accept;
    logic                  rd_accept;
    logic                  push;
    logic                  pop;

    // Handshake and response flags. Reads count against FIFO space
    // together with the read still in the macro, so a push can never overflow.
    // Everything is held quiet while rst0 is asserted.
    always_comb begin
        outstanding = fifo_count + CNT_W'(rd_inflight);
        rsp_valid   = !rst0 && (fifo_count != '0);
        rsp_rdata   = rsp_valid ? fifo_mem[rd_ptr] : '0;
        init_done   = !rst0 && (state_q == ST_RUN);
        req_ready   = init_done && (req_we || (outstanding < CNT_W'(RSP_DEPTH)));
        accept      = req_valid && req_ready;
        rd_accept   = accept && !req_we;
        push        = rd_inflight;
        pop         = rsp_valid && rsp_ready;
    end

    // Next state and macro drive. The command is combinational so the macro
    // samples it on the same edge the controller commits it.
    always_comb begin
        state_d = state_q;
        csb0    = 1'b1;
        web0    = 1'b1;
        addr0   = addr_q;
        din0    = din_q;
        if (rst0) begin
            addr0 = '0;
            din0  = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    csb0  = 1'b0;
                    web0  = 1'b0;
                    addr0 = init_ptr;
                    din0  = INIT_VALUE;
                    if (init_ptr == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        csb0  = 1'b0;
                        web0  = !req_we;
                        addr0 = req_addr;
                        din0  = req_wdata;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State register and clear pointer; the clear always restarts at address 0.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q  <= INIT_EN ? ST_INIT : ST_RUN;
            init_ptr <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                init_ptr <= init_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Remember the last issued address/data so idle cycles leave them unchanged.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            addr_q <= '0;
            din_q  <= '0;
        end else if (!csb0) begin
            addr_q <= addr0;
            din_q  <= din0;
        end
    end

    // A read in the macro returns data for exactly one edge; track it so that
    // edge pushes dout0. Reset drops it.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_accept;
        end
    end

    // Response FIFO pointers and occupancy; push and pop together keep count.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    // Response storage: capture dout0 on the edge where the macro holds it valid.
    always_ff @(posedge clk0) begin
        if (!rst0 && push) begin
            fifo_mem[wr_ptr] <= dout0;
        end
    end

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// tb_sram_1rw_req_ctrl: directed bench for sram_1rw_req_ctrl with a behavioural
// SRAM macro, a transaction-level reference model and a per-cycle compare.
module tb_sram_1rw_req_ctrl;

    localparam int         AW     = 4;
    localparam int         DW     = 2;
    localparam int         DEPTH  = 16;
    localparam int         RSPD   = 4;
    localparam logic [1:0] INIT_V = 2'b00;

    logic          clk0      = 1'b0;
    logic          rst0      = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          csb0;
    logic          web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0     = '0;

    logic          req_valid_b = 1'b0;
    logic          req_we_b    = 1'b0;
    logic [AW-1:0] req_addr_b  = 4'd7;
    logic [DW-1:0] req_wdata_b = 2'd2;
    logic          rsp_ready_b = 1'b0;
    logic [DW-1:0] dout0_b     = 2'b01;
    logic          req_ready_b;
    logic          rsp_valid_b;
    logic [DW-1:0] rsp_rdata_b;
    logic          init_done_b;
    logic          csb0_b;
    logic          web0_b;
    logic [AW-1:0] addr0_b;
    logic [DW-1:0] din0_b;

    int errors = 0;
    int checks = 0;

    sram_1rw_req_ctrl dut (
        .clk0(clk0), .rst0(rst0),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
    );

    sram_1rw_req_ctrl #(.INIT_EN(1'b0), .INIT_VALUE(2'b11)) dut_b (
        .clk0(clk0), .rst0(rst0),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
        .init_done(init_done_b),
        .csb0(csb0_b), .web0(web0_b), .addr0(addr0_b), .din0(din0_b), .dout0(dout0_b)
    );

    always #5 clk0 = ~clk0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic rr);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = rr;
        @(posedge clk0);
        #1;
    endtask

    // Behavioural macro: latch the command at posedge, perform it at the
    // following negedge, and scramble dout0 just after the next posedge.
    logic [DW-1:0] sram_mem [DEPTH];
    bit            pend_cs = 1'b0, pend_we = 1'b0, act_cs = 1'b0, act_we = 1'b0;
    logic [AW-1:0] pend_addr = '0, act_addr = '0;
    logic [DW-1:0] pend_din = '0, act_din = '0;

    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = 2'b11;
        forever begin
            @(posedge clk0);
            act_cs   = pend_cs;
            act_we   = pend_we;
            act_addr = pend_addr;
            act_din  = pend_din;
            #1 dout0 = ~dout0;
            @(negedge clk0);
            if (act_cs) begin
                if (act_we) sram_mem[act_addr] = act_din;
                else        dout0 = sram_mem[act_addr];
            end
            pend_cs   = !csb0;
            pend_we   = !web0;
            pend_addr = addr0;
            pend_din  = din0;
        end
    end

    // Reference model: memory contents, clear countdown and a queue of
    // expected responses (data plus edges still to wait before visible).
    int            init_rem  = 0;
    bit            live      = 1'b0;
    logic [DW-1:0] ref_mem [DEPTH];
    int            q_data[$];
    int            q_wait[$];
    int            last_addr = 0, last_din = 0;
    int            cyc = 0, done_cyc = 0, cyc_abs = 0;
    int            clear_writes = 0, clear_ok = 0;
    int            b_cmds = 0, hs_count = 0, rd_hs_count = 0;
    int            got_rsp[$];
    int            got_cyc[$];

    always @(negedge clk0) begin : compare
        bit exp_cs, exp_we, exp_rdy, hs, exp_rv;
        int exp_addr, exp_din;
        cyc_abs++;
        if (!rst0 && !csb0_b) b_cmds++;
        if (rst0) begin
            checkOutput("rst_csb0", int'(csb0), 1);
            checkOutput("rst_web0", int'(web0), 1);
            checkOutput("rst_addr0", int'(addr0), 0);
            checkOutput("rst_din0", int'(din0), 0);
            checkOutput("rst_req_ready", int'(req_ready), 0);
            checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
            checkOutput("rst_rsp_rdata", int'(rsp_rdata), 0);
            checkOutput("rst_init_done", int'(init_done), 0);
            init_rem  = DEPTH;
            q_data.delete();
            q_wait.delete();
            last_addr = 0;
            last_din  = 0;
            live      = 1'b1;
            cyc = 0; done_cyc = 0; clear_writes = 0; clear_ok = 0;
        end else if (live) begin
            cyc++;
            if (init_done && done_cyc == 0) done_cyc = cyc;
            if (!csb0 && !web0 && !init_done) begin
                if (int'(addr0) == clear_writes && din0 == INIT_V) clear_ok++;
                clear_writes++;
            end
            exp_rdy = (init_rem == 0) && (req_we || q_data.size() < RSPD);
            hs      = req_valid && exp_rdy;
            if (init_rem > 0) begin
                exp_cs = 1'b1; exp_we = 1'b1; exp_addr = DEPTH - init_rem; exp_din = int'(INIT_V);
            end else if (hs) begin
                exp_cs = 1'b1; exp_we = req_we; exp_addr = int'(req_addr); exp_din = int'(req_wdata);
            end else begin
                exp_cs = 1'b0; exp_we = 1'b0; exp_addr = last_addr; exp_din = last_din;
            end
            exp_rv = (q_data.size() > 0) && (q_wait[0] == 0);
            checkOutput("req_ready", int'(req_ready), int'(exp_rdy));
            checkOutput("csb0", int'(csb0), int'(!exp_cs));
            checkOutput("web0", int'(web0), int'(!exp_we));
            checkOutput("addr0", int'(addr0), exp_addr);
            checkOutput("din0", int'(din0), exp_din);
            checkOutput("init_done", int'(init_done), int'(init_rem == 0));
            checkOutput("rsp_valid", int'(rsp_valid), int'(exp_rv));
            if (exp_rv) checkOutput("rsp_rdata", int'(rsp_rdata), q_data[0]);
            if (rsp_valid && rsp_ready) begin
                got_rsp.push_back(int'(rsp_rdata));
                got_cyc.push_back(cyc_abs);
            end
            if (req_valid && req_ready) begin
                hs_count++;
                if (!req_we) rd_hs_count++;
            end
            if (exp_rv && rsp_ready) begin
                void'(q_data.pop_front());
                void'(q_wait.pop_front());
            end
            foreach (q_wait[i]) if (q_wait[i] > 0) q_wait[i]--;
            if (init_rem > 0) begin
                ref_mem[DEPTH - init_rem] = INIT_V;
                last_addr = DEPTH - init_rem;
                last_din  = int'(INIT_V);
                init_rem--;
            end else if (hs) begin
                last_addr = int'(req_addr);
                last_din  = int'(req_wdata);
                if (req_we) begin
                    ref_mem[req_addr] = req_wdata;
                end else begin
                    q_data.push_back(int'(ref_mem[req_addr]));
                    q_wait.push_back(1);
                end
            end
        end
    end

    initial begin
        int base;
        int exp_bp[6] = '{0, 1, 2, 3, 0, 1};

        // Reset, then let the clear run while idle for 20 cycles.
        repeat (2) begin @(posedge clk0); #1; end
        rst0        = 1'b0;
        req_valid_b = 1'b1;
        #1;
        checkOutput("b_ready_first", int'(req_ready_b), 1);
        checkOutput("b_csb0_first", int'(csb0_b), 0);
        checkOutput("b_web0_first", int'(web0_b), 1);
        checkOutput("b_addr0_first", int'(addr0_b), 7);
        checkOutput("b_din0_first", int'(din0_b), 2);
        checkOutput("b_init_done_first", int'(init_done_b), 1);
        checkOutput("clear_first_csb0", int'(csb0), 0);
        checkOutput("clear_first_addr0", int'(addr0), 0);
        checkOutput("clear_first_ready", int'(req_ready), 0);
        applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
        req_valid_b = 1'b0;
        repeat (19) applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
        checkOutput("clear_writes", clear_writes, 16);
        checkOutput("clear_addr_data", clear_ok, 16);
        checkOutput("init_done_cycle", done_cyc, 17);
        checkOutput("b_no_clear", b_cmds, 1);
        checkOutput("b_rsp_valid", int'(rsp_valid_b), 1);
        checkOutput("b_rsp_rdata", int'(rsp_rdata_b), 1);

        // Read of a cleared word.
        got_rsp.delete();
        applyStimulus(1'b1, 1'b0, 4'd5, 2'd0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
        checkOutput("rd5_count", got_rsp.size(), 1);
        checkOutput("rd5_data", (got_rsp.size() > 0) ? got_rsp[0] : -1, 0);

        // Write then read of the same address on consecutive cycles.
        applyStimulus(1'b1, 1'b1, 4'd3, 2'b10, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'd3, 2'd0, 1'b1);
        checkOutput("wr_rd_early", int'(rsp_valid), 0);
        applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
        checkOutput("wr_rd_valid", int'(rsp_valid), 1);
        checkOutput("wr_rd_data", int'(rsp_rdata), 2);
        repeat (2) applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 1'b1);

        // Fill with addr[1:0], then 16 back-to-back reads.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, AW'(i), DW'(i), 1'b1);
        got_rsp.delete();
        got_cyc.delete();
        base = hs_count;
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, AW'(i), 2'd0, 1'b1);
        checkOutput("b2b_accepted", hs_count - base, 16);
        repeat (4) applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
        checkOutput("b2b_count", got_rsp.size(), 16);
        for (int i = 0; i < DEPTH; i++)
            checkOutput("b2b_data", (i < got_rsp.size()) ? got_rsp[i] : -1, i % 4);
        checkOutput("b2b_no_gaps", (got_cyc.size() == 16) ? got_cyc[15] - got_cyc[0] : -1, 15);

        // Backpressure: six reads of 4..9 with the consumer stalled.
        got_rsp.delete();
        base = rd_hs_count;
        for (int k = 0; k < 8; k++) begin
            int acc;
            acc = rd_hs_count - base;
            if (acc < 6) applyStimulus(1'b1, 1'b0, AW'(4 + acc), 2'd0, 1'b0);
            else         applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
        end
        checkOutput("bp_accepted", rd_hs_count - base, 4);
        checkOutput("bp_ready_low", int'(req_ready), 0);
        checkOutput("bp_rsp_held", int'(rsp_valid), 1);
        checkOutput("bp_no_pop", got_rsp.size(), 0);
        begin
            int wbase;
            wbase = hs_count;
            applyStimulus(1'b1, 1'b1, 4'd12, 2'd3, 1'b0);
            checkOutput("bp_write_accepted", hs_count - wbase, 1);
        end
        for (int k = 0; k < 12; k++) begin
            int acc;
            acc = rd_hs_count - base;
            if (acc < 6) applyStimulus(1'b1, 1'b0, AW'(4 + acc), 2'd0, 1'b1);
            else         applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
        end
        checkOutput("bp_all_reads", rd_hs_count - base, 6);
        checkOutput("bp_rsp_count", got_rsp.size(), 6);
        for (int i = 0; i < 6; i++)
            checkOutput("bp_rsp_data", (i < got_rsp.size()) ? got_rsp[i] : -1, exp_bp[i]);

        // Reset right after a read handshake: the read must vanish.
        got_rsp.delete();
        applyStimulus(1'b1, 1'b0, 4'd2, 2'd0, 1'b1);
        rst0      = 1'b1;
        req_valid = 1'b0;
        #1;
        checkOutput("midrst_csb0", int'(csb0), 1);
        checkOutput("midrst_rsp_valid", int'(rsp_valid), 0);
        @(posedge clk0);
        #1;
        rst0 = 1'b0;
        repeat (20) applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
        checkOutput("midrst_no_rsp", got_rsp.size(), 0);
        checkOutput("midrst_clear_writes", clear_writes, 16);
        checkOutput("midrst_clear_addr_data", clear_ok, 16);
        checkOutput("midrst_done_cycle", done_cyc, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
